// File: rtl/score_buffer.sv
// Collects per-class float32 scores into a parallel bank and holds the frame for argmax.
// Optional running max tracking under SCORE_RUNMAX_EN.
module score_buffer #(
    parameter int unsigned N_SCORES = 10,
    parameter int unsigned IDX_W    = 5
) (
    input  logic                         Clk,
    input  logic                         Reset,
    input  logic                         clear,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [31:0]                  in_data,
    input  logic                         in_last,
    output logic [N_SCORES-1:0][31:0]    scores,
    output logic                         scores_valid,
    input  logic                         consume,
    output logic                         err,
    output logic [IDX_W-1:0]             max_idx,
    output logic [31:0]                  max_score
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SCORES - 1);

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_t;

    state_t                      r_state;
    logic [IDX_W-1:0]            r_count;
    logic [N_SCORES-1:0][31:0]   r_scores;
    logic                        r_ready;
    logic                        r_valid;
    logic                        r_err;
    logic                        w_beat;
    logic                        w_last_pos;

    assign w_beat     = in_valid && r_ready;
    assign w_last_pos = (r_count == LAST_IDX);

`ifdef SCORE_RUNMAX_EN
    logic [IDX_W-1:0]            r_max_idx;
    logic [31:0]                 r_max_score;

    // Signed IEEE ordering; +0 and -0 are equal, so neither is greater.
    function automatic logic f_gt(input logic [31:0] a, input logic [31:0] b);
        if ((a[30:0] == 31'd0) && (b[30:0] == 31'd0))
            return 1'b0;
        if (a[31] != b[31])
            return !a[31];
        if (!a[31])
            return a[30:0] > b[30:0];
        return a[30:0] < b[30:0];
    endfunction
`endif

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state  <= FILL;
            r_count  <= '0;
            r_scores <= '0;
            r_ready  <= 1'b1;
            r_valid  <= 1'b0;
            r_err    <= 1'b0;
`ifdef SCORE_RUNMAX_EN
            r_max_idx   <= '0;
            r_max_score <= '0;
`endif
        end else if (clear) begin
            r_state <= FILL;
            r_count <= '0;
            r_ready <= 1'b1;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
`ifdef SCORE_RUNMAX_EN
            r_max_idx   <= '0;
            r_max_score <= '0;
`endif
        end else begin
            case (r_state)
                FILL: begin
                    if (w_beat) begin
                        for (int i = 0; i < int'(N_SCORES); i++) begin
                            if (r_count == IDX_W'(i))
                                r_scores[i] <= in_data;
                        end
                        // Frame length is fixed by count; in_last only flags errors.
                        if (in_last != w_last_pos)
                            r_err <= 1'b1;
`ifdef SCORE_RUNMAX_EN
                        if ((r_count == '0) || f_gt(in_data, r_max_score)) begin
                            r_max_idx   <= r_count;
                            r_max_score <= in_data;
                        end
`endif
                        if (w_last_pos) begin
                            r_state <= FULL;
                            r_count <= '0;
                            r_ready <= 1'b0;
                            r_valid <= 1'b1;
                        end else begin
                            r_count <= r_count + IDX_W'(1);
                        end
                    end
                end
                FULL: begin
                    if (consume) begin
                        r_state <= FILL;
                        r_ready <= 1'b1;
                        r_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state <= FILL;
                    r_count <= '0;
                    r_ready <= 1'b1;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready     = r_ready;
    assign scores       = r_scores;
    assign scores_valid = r_valid;
    assign err          = r_err;

`ifdef SCORE_RUNMAX_EN
    assign max_idx   = r_max_idx;
    assign max_score = r_max_score;
`else
    assign max_idx   = '0;
    assign max_score = '0;
`endif

endmodule

// File: tb/tb_score_buffer.sv
// Self-checking bench for score_buffer: directed vector table, hand sequences, random vs model.
module tb_score_buffer;

    localparam int unsigned N     = 10;
    localparam int unsigned IDX_W = 5;

    logic                  clk;
    logic                  rst;
    logic                  clear;
    logic                  in_valid;
    logic                  in_ready;
    logic [31:0]           in_data;
    logic                  in_last;
    logic [N-1:0][31:0]    scores;
    logic                  scores_valid;
    logic                  consume;
    logic                  err;
    logic [IDX_W-1:0]      max_idx;
    logic [31:0]           max_score;

    score_buffer #(.N_SCORES(N), .IDX_W(IDX_W)) dut (
        .Clk(clk), .Reset(rst), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .scores(scores), .scores_valid(scores_valid), .consume(consume),
        .err(err), .max_idx(max_idx), .max_score(max_score)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: current-frame beats, bank image, sticky error, holding flag, max.
    logic [31:0] m_q[$];
    logic [31:0] m_bank[N];
    bit          m_full;
    bit          m_err;
    int          m_max_idx;
    logic [31:0] m_max_score;

    typedef struct {
        bit          v;
        logic [31:0] d;
        bit          last;
        bit          clr;
        bit          cons;
        bit          e_rdy;
        bit          e_sv;
        bit          e_err;
    } vec_t;
    vec_t vt[$];

    function automatic real f2r(input logic [31:0] x);
        int  e;
        real m;
        real v;
        e = int'(x[30:23]);
        m = real'(x[22:0]) / 8388608.0;
        if (e == 0) v = m * (2.0 ** (-126));
        else        v = (1.0 + m) * (2.0 ** (e - 127));
        return x[31] ? -v : v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        for (int i = 0; i < int'(N); i++) m_bank[i] = 32'h0;
        m_full = 0; m_err = 0; m_max_idx = 0; m_max_score = 32'h0;
    endtask

    task automatic model_step(input bit v, input logic [31:0] d, input bit last,
                              input bit clr, input bit cons);
        int pos;
        int best;
        if (clr) begin
            m_full = 0; m_err = 0; m_q.delete();
            m_max_idx = 0; m_max_score = 32'h0;
        end else if (m_full) begin
            if (cons) m_full = 0;
        end else if (v) begin
            pos = m_q.size();
            m_bank[pos] = d;
            if (last != (pos == int'(N) - 1)) m_err = 1;
            m_q.push_back(d);
            best = 0;
            for (int i = 1; i < m_q.size(); i++)
                if (f2r(m_q[i]) > f2r(m_q[best])) best = i;
            m_max_idx = best;
            m_max_score = m_q[best];
            if (m_q.size() == int'(N)) begin
                m_full = 1;
                m_q.delete();
            end
        end
    endtask

    task automatic chk_model();
        chk("in_ready", 32'(in_ready), 32'(!m_full));
        chk("scores_valid", 32'(scores_valid), 32'(m_full));
        chk("err", 32'(err), 32'(m_err));
        for (int i = 0; i < int'(N); i++) chk("bank", scores[i], m_bank[i]);
`ifdef SCORE_RUNMAX_EN
        chk("max_idx", 32'(max_idx), 32'(m_max_idx));
        chk("max_score", max_score, m_max_score);
`else
        chk("max_idx_off", 32'(max_idx), 32'h0);
        chk("max_score_off", max_score, 32'h0);
`endif
    endtask

    task automatic cycle(input bit v, input logic [31:0] d, input bit last,
                         input bit clr, input bit cons);
        in_valid = v; in_data = d; in_last = last; clear = clr; consume = cons;
        @(posedge clk);
        model_step(v, d, last, clr, cons);
        #1;
        chk_model();
    endtask

    task automatic frame(input logic [31:0] vals[N]);
        for (int i = 0; i < int'(N); i++)
            cycle(1'b1, vals[i], i == int'(N) - 1, 1'b0, 1'b0);
    endtask

    function automatic void add(input bit v, input logic [31:0] d, input bit last,
                                input bit clr, input bit cons,
                                input bit rdy, input bit sv, input bit e);
        vec_t t;
        t.v = v; t.d = d; t.last = last; t.clr = clr; t.cons = cons;
        t.e_rdy = rdy; t.e_sv = sv; t.e_err = e;
        vt.push_back(t);
    endfunction

    function automatic logic [31:0] rnd_f();
        logic [31:0] r;
        case ($urandom_range(0, 7))
            0: r = 32'h40400000;
            1: r = 32'h00000000;
            2: r = 32'h80000000;
            default: begin
                r = $urandom;
                r[30:23] = 8'(120 + $urandom_range(0, 15));
            end
        endcase
        return r;
    endfunction

    logic [31:0] fr[N];
    logic [31:0] int_f[N];

    initial begin
        int_f[0] = 32'h00000000; int_f[1] = 32'h3F800000; int_f[2] = 32'h40000000;
        int_f[3] = 32'h40400000; int_f[4] = 32'h40800000; int_f[5] = 32'h40A00000;
        int_f[6] = 32'h40C00000; int_f[7] = 32'h40E00000; int_f[8] = 32'h41000000;
        int_f[9] = 32'h41100000;

        rst = 1'b1; clear = 0; in_valid = 0; in_data = 0; in_last = 0; consume = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_model();
        chk("rst_ready", 32'(in_ready), 32'h1);
        rst = 1'b0;

        // Directed table: frame of float(i), hold, consume, bad framing, clear cases.
        for (int i = 0; i < int'(N); i++)
            add(1, int_f[i], i == 9, 0, 0, i != 9, i == 9, 0);
        for (int i = 0; i < 5; i++) add(1, 32'hDEADBEEF, 0, 0, 0, 0, 1, 0);
        add(0, 0, 0, 0, 1, 1, 0, 0);
        for (int i = 0; i < int'(N); i++)
            add(1, int_f[N-1-i], i == 3, 0, 0, i != 9, i == 9, i >= 3);
        add(0, 0, 0, 1, 1, 1, 0, 0);
        for (int i = 0; i < 3; i++) add(1, int_f[i], 0, 0, 0, 1, 0, 0);
        add(1, 32'h12345678, 0, 1, 0, 1, 0, 0);
        for (int i = 0; i < int'(N); i++)
            add(1, int_f[i], i == 9, 0, 0, i != 9, i == 9, 0);

        for (int k = 0; k < vt.size(); k++) begin
            cycle(vt[k].v, vt[k].d, vt[k].last, vt[k].clr, vt[k].cons);
            chk("vec_ready", 32'(in_ready), 32'(vt[k].e_rdy));
            chk("vec_valid", 32'(scores_valid), 32'(vt[k].e_sv));
            chk("vec_err", 32'(err), 32'(vt[k].e_err));
            if (k == 9) begin
                for (int i = 0; i < int'(N); i++) chk("vec_bank", scores[i], int_f[i]);
`ifdef SCORE_RUNMAX_EN
                chk("vec_max_idx", 32'(max_idx), 32'd9);
                chk("vec_max_score", max_score, 32'h41100000);
`endif
            end
        end
        cycle(0, 0, 0, 0, 1);

        // Max with mixed signs, then a tie resolved to the lower index.
        for (int i = 0; i < int'(N); i++) fr[i] = 32'hBF800000;
        fr[6] = 32'hC0000000; fr[2] = 32'h3F000000;
        frame(fr);
`ifdef SCORE_RUNMAX_EN
        chk("max_mixed", 32'(max_idx), 32'd2);
`endif
        cycle(0, 0, 0, 0, 1);
        fr[4] = 32'h40400000; fr[7] = 32'h40400000;
        frame(fr);
`ifdef SCORE_RUNMAX_EN
        chk("max_tie", 32'(max_idx), 32'd4);
`endif
        cycle(0, 0, 0, 0, 1);

        // Asynchronous reset mid-frame, then a complete frame.
        for (int i = 0; i < 6; i++) cycle(1, int_f[i], 0, 0, 0);
        in_valid = 0;
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk_model();
        chk("arst_valid", 32'(scores_valid), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        frame(int_f);
        chk("arst_frame_valid", 32'(scores_valid), 32'h1);
        chk("arst_frame_err", 32'(err), 32'h0);
        cycle(0, 0, 0, 0, 1);

        // Random traffic with gaps, framing errors, clears and consume delays.
        for (int c = 0; c < 2000; c++) begin
            bit lst;
            lst = (m_q.size() == int'(N) - 1);
            if ($urandom_range(0, 15) == 0) lst = !lst;
            cycle($urandom_range(0, 3) != 0, rnd_f(), lst,
                  $urandom_range(0, 63) == 0, $urandom_range(0, 2) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/score_buffer.md
# score_buffer

Collects the output layer's per-class float32 scores, one per handshake beat, into a parallel register bank. It presents the complete frame to the classifier's argmax stage and holds it until that stage acknowledges it. The block sits between the serial output-layer MAC pipeline and the combinational argmax. Optionally it also tracks the running maximum score and its class index while the frame is being filled.

## Interface
Parameters:
- N_SCORES, 10: scores per frame (class count); must be 2..31
- IDX_W, 5: width of the beat counter and the class index output

Ports:
- Clk  in  1  system clock; all state updates on the rising edge
- Reset  in  1  asynchronous, active-high reset
- clear  in  1  synchronous frame abort/restart; clears the frame state and err
- in_valid  in  1  producer has a score on in_data
- in_ready  out  1  block accepts a score this cycle
- in_data  in  32  IEEE-754 single-precision score
- in_last  in  1  producer marks the final score of the frame
- scores  out  32 x N_SCORES  score bank; scores[i] is class i
- scores_valid  out  1  bank holds a complete frame
- consume  in  1  argmax side is done with the frame; bank is released
- err  out  1  sticky framing error
- max_idx  out  IDX_W  index of the largest score so far (SCORE_RUNMAX_EN only)
- max_score  out  32  value of the largest score so far (SCORE_RUNMAX_EN only)

## Operation
- FSM states are FILL and FULL. Reset places the FSM in FILL with count=0.
- Reset values: in_ready=1, scores all 0, scores_valid=0, err=0, max_idx=0, max_score=0.
- FILL behaviour:
  - in_ready=1.
  - A beat occurs when in_valid && in_ready. Each beat writes scores[count]<=in_data and increments count.
  - The beat with count==N_SCORES-1 moves the FSM to FULL and resets count to 0.
- FULL behaviour:
  - in_ready=0 and scores_valid=1.
  - The bank and the max outputs are frozen.
  - consume=1 returns the FSM to FILL.
- Framing checks:
  - in_last=1 on a beat with count!=N_SCORES-1 sets err.
  - in_last=0 on the beat with count==N_SCORES-1 sets err.
  - Framing is always decided by count; in_last never shortens or extends a frame.
- clear:
  - Moves the FSM to FILL with count=0, scores_valid=0, err=0.
  - Bank contents are left untouched.
  - If clear is asserted in the same cycle as a beat, clear wins and the beat is discarded.
- clear has priority over consume. consume in FILL is ignored.
- Float ordering, used only by SCORE_RUNMAX_EN:
  - Full signed IEEE compare.
  - If the signs differ, the positive value is greater.
  - If both are positive, the larger {exp,mantissa} is greater.
  - If both are negative, the smaller {exp,mantissa} is greater.
  - +0 and -0 compare equal. NaN/Inf are not treated specially.

## Timing
- in_ready is a registered function of the state; it drops in the cycle after the final beat.
- scores_valid rises in the cycle after the final beat, so latency from the last beat to a valid frame is 1 cycle.
- consume is sampled on the edge; scores_valid=0 and in_ready=1 in the following cycle. The earliest next-frame beat is 1 cycle after consume.
- Minimum frame period is N_SCORES+1 cycles when consume is tied high.
- err, max_idx and max_score update on the same edge as the beat that causes the change.
- A Reset mid-frame discards the partial frame immediately (asynchronous reset), with all outputs taking their reset values.

## Configuration
- Macro: SCORE_RUNMAX_EN.
- Defined:
  - Beat 0 of each frame loads max_score<=in_data and max_idx<=0.
  - Later beats replace both only if in_data is strictly greater; ties keep the earlier index, i.e. lowest-index priority.
  - The values are final once scores_valid=1.
  - clear resets both to 0.
- Undefined: max_idx and max_score are constant 0, and no compare logic is synthesized.

## Test plan
- Reset, then 10 back-to-back beats with scores[i]=float(i) and in_last on beat 9 -> scores_valid=1 in the cycle after beat 9, in_ready=0, bank matches, err=0, max_idx=9, max_score=0x41100000.
- Hold consume=0 for 5 cycles with in_valid=1 -> bank unchanged and no beats accepted. Pulse consume -> in_ready=1 in the next cycle and a new frame fills.
- in_last asserted on beat 3 -> err=1 and stays set. The frame still completes after 10 beats. clear -> err=0, scores_valid=0.
- Scores all 0xBF800000 (-1.0) except beat 6=0xC0000000 (-2.0) and beat 2=0x3F000000 (0.5) -> max_idx=2. Repeat with beats 4 and 7 both 0x40400000, the maximum -> max_idx=4.
- Assert Reset asynchronously after beat 5, then deassert -> outputs reset, count=0, and the next 10 beats form a complete frame.
- clear asserted in the same cycle as a beat and with consume in FULL -> the beat is discarded, the FSM is in FILL, and scores_valid=0.
